// File: rtl/irq_request_latch_pkg.sv
// Shared types for the request latch / encoder slice.
// Default index width and request detection modes.
package irq_request_latch_pkg;

    localparam int unsigned DEF_OUT_WIDTH = 3;

    typedef enum logic {
        DET_LEVEL = 1'b0,
        DET_EDGE  = 1'b1
    } det_mode_e;

endpackage

// File: rtl/irq_request_latch_encoder.sv
// One-hot to binary encoder; input is one-hot or zero.
// Zero input yields zero output, which the caller ignores.
module irq_request_latch_encoder #(
    parameter int unsigned OUT_WIDTH = 3
) (
    input  logic [(1<<OUT_WIDTH)-1:0] i_oh,
    output logic [OUT_WIDTH-1:0]      o_idx
);

    localparam int unsigned N = 1 << OUT_WIDTH;

    always_comb begin
        o_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_oh[i]) begin
                o_idx = o_idx | OUT_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/irq_request_latch.sv
// Sticky request latch with lowest-index pick and a registered
// valid/ready index port.
module irq_request_latch
    import irq_request_latch_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter bit          EDGE      = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [(1<<OUT_WIDTH)-1:0]  req_in,
    input  logic [(1<<OUT_WIDTH)-1:0]  mask,
    input  logic                       clr_all,
    output logic                       idx_valid,
    input  logic                       idx_ready,
    output logic [OUT_WIDTH-1:0]       idx,
    output logic [(1<<OUT_WIDTH)-1:0]  pending,
    output logic                       overrun
);

    localparam int unsigned N = 1 << OUT_WIDTH;
    localparam det_mode_e   MODE = det_mode_e'(EDGE);
    localparam logic [N-1:0] PREV_EN = (MODE == DET_EDGE) ? '1 : '0;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]         r_prev_req;
    logic [N-1:0]         r_pending;
    logic [OUT_WIDTH-1:0] r_idx;
    logic                 r_idx_valid;
    logic                 r_overrun;

    logic [N-1:0]         w_hit;
    logic                 w_accept;
    logic [N-1:0]         w_acc_oh;
    logic [N-1:0]         w_clr_vec;
    logic [N-1:0]         w_pending_nxt;
    logic [N-1:0]         w_cand;
    logic [N-1:0]         w_sel;
    logic                 w_any;
    logic                 w_load;
    logic [OUT_WIDTH-1:0] w_enc_idx;

    // Level mode ignores history, so prev_req is masked out entirely.
    assign w_hit     = req_in & ~(r_prev_req & PREV_EN);
    assign w_accept  = r_idx_valid & idx_ready;
    assign w_acc_oh  = w_accept ? (ONE << r_idx) : '0;
    assign w_clr_vec = {N{clr_all}} | w_acc_oh;

    assign w_pending_nxt = w_hit | (r_pending & ~w_clr_vec);

    // The line being handed over this cycle must not be re-picked.
    assign w_cand = r_pending & ~mask & ~w_acc_oh;
    assign w_sel  = w_cand & (~w_cand + ONE);
    assign w_any  = |w_cand;
    assign w_load = ~r_idx_valid | w_accept;

    irq_request_latch_encoder #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_enc (
        .i_oh  (w_sel),
        .o_idx (w_enc_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_req <= '0;
            r_pending  <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_prev_req <= req_in;
            r_pending  <= w_pending_nxt;
            r_overrun  <= |(w_hit & r_pending & ~w_clr_vec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx_valid <= 1'b0;
            r_idx       <= '0;
        end else if (clr_all) begin
            r_idx_valid <= 1'b0;
        end else if (w_load) begin
            r_idx_valid <= w_any;
            if (w_any) begin
                r_idx <= w_enc_idx;
            end
        end
    end

    assign idx_valid = r_idx_valid;
    assign idx       = r_idx;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule
